// File: rtl/window_gen_kxk_pkg.sv
// Shared helpers for the KxK window generator: tap indexing, coordinate
// widths and the zero-pad mode encodings.
package window_gen_kxk_pkg;

  localparam int ZP_RAW  = 0;  // out-of-frame taps pass stale buffer contents
  localparam int ZP_ZERO = 1;  // out-of-frame taps read as zero

  // Flat tap index of window position (row i, column j).
  function automatic int tap_idx(input int i, input int j, input int k);
    return i * k + j;
  endfunction

  // Counter width for a dimension of n positions (at least one bit).
  function automatic int coord_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/window_gen_kxk_line_delay.sv
// Clock-enabled IMG_W-deep pixel delay; one full image line between taps.
// No reset: contents are masked downstream until overwritten by live data.
module line_delay #(
  parameter int DW    = 10,
  parameter int IMG_W = 640
)(
  input  logic          clk,
  input  logic          i_en,
  input  logic [DW-1:0] i_din,
  output logic [DW-1:0] o_dout
);

  logic [IMG_W-1:0][DW-1:0] r_mem;

  // Shift one slot per accepted pixel; oldest entry sits at the top.
  always_ff @(posedge clk) begin
    if (i_en) r_mem <= {r_mem[IMG_W-2:0], i_din};
  end

  assign o_dout = r_mem[IMG_W-1];

endmodule

// File: rtl/window_gen_kxk.sv
// KxK sliding-window generator: raster counters, K-1 line delays, window
// register and edge mask. Window appears one clock after the accepted pixel.
module window_gen_kxk
  import window_gen_kxk_pkg::*;
#(
  parameter int DW       = 10,
  parameter int K        = 3,
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int ZERO_PAD = ZP_ZERO
)(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      aclr,
  input  logic                      ien,
  input  logic                      isof,
  input  logic [DW-1:0]             per_img_Y,
  output logic                      oen,
  output logic [K*K*DW-1:0]         win_data,
  output logic [coord_w(IMG_H)-1:0] win_row,
  output logic [coord_w(IMG_W)-1:0] win_col,
  output logic                      win_inside
);

  localparam int RW = coord_w(IMG_H);
  localparam int CW = coord_w(IMG_W);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);

  logic [RW-1:0] r_row, r_orow, w_row, w_row_nxt;
  logic [CW-1:0] r_col, r_ocol, w_col, w_col_nxt;
  logic          r_oen;
  logic          w_en;
  logic [K-1:0][K-1:0][DW-1:0] r_win;
  logic [K-1:0][DW-1:0]        w_rowin;

  // aclr drops the pixel, so the line delays must not advance either.
  assign w_en = ien & ~aclr;

  // Coordinates of the pixel being accepted (isof forces the frame origin)
  // and the raster position that follows it.
  always_comb begin
    w_row     = isof ? '0 : r_row;
    w_col     = isof ? '0 : r_col;
    w_col_nxt = w_col + 1'b1;
    w_row_nxt = w_row;
    if (w_col == LAST_COL) begin
      w_col_nxt = '0;
      w_row_nxt = (w_row == LAST_ROW) ? '0 : w_row + 1'b1;
    end
  end

  // Newest row is the live pixel; each older row comes one more line back.
  assign w_rowin[K-1] = per_img_Y;

  genvar d;
  for (d = 0; d < K - 1; d++) begin : g_dly
    line_delay #(.DW(DW), .IMG_W(IMG_W)) u_dly (
      .clk    (clk),
      .i_en   (w_en),
      .i_din  (w_rowin[K-1-d]),
      .o_dout (w_rowin[K-2-d])
    );
  end

  // Counters, window shift and output coordinate registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row  <= '0;
      r_col  <= '0;
      r_orow <= '0;
      r_ocol <= '0;
      r_oen  <= 1'b0;
      r_win  <= '0;
    end else if (aclr) begin
      r_row  <= '0;
      r_col  <= '0;
      r_orow <= '0;
      r_ocol <= '0;
      r_oen  <= 1'b0;
      r_win  <= '0;
    end else begin
      r_oen <= ien;
      if (ien) begin
        r_row  <= w_row_nxt;
        r_col  <= w_col_nxt;
        r_orow <= w_row;
        r_ocol <= w_col;
        for (int i = 0; i < K; i++)
          r_win[i] <= {w_rowin[i], r_win[i][K-1:1]};
      end
    end
  end

  // Edge mask on the newest pixel's coordinates; register contents untouched.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        if (ZERO_PAD == ZP_RAW ||
            (int'(r_orow) >= K - 1 - i && int'(r_ocol) >= K - 1 - j))
          win_data[tap_idx(i, j, K)*DW +: DW] = r_win[i][j];
      end
    end
  end

  assign oen        = r_oen;
  assign win_row    = r_orow;
  assign win_col    = r_ocol;
  assign win_inside = (int'(r_orow) >= K - 1) && (int'(r_ocol) >= K - 1);

endmodule

// File: tb/tb_window_gen_kxk.sv
// Bench for window_gen_kxk: scoreboard on a 3x3/8x6 zero-padded instance,
// spot table on the first frame, hand sequences for resync/clear/reset,
// and a 5x5 raw-mode instance for frame wrap and stale-tap behaviour.
module tb_window_gen_kxk;

  localparam int DW = 10, K = 3, W = 8, H = 6, NT = K * K;

  typedef struct {
    logic [2:0]       row;
    logic [2:0]       col;
    logic             ins;
    logic [NT*DW-1:0] win;
  } exp_t;

  typedef struct {
    int               r;
    int               c;
    logic [NT*DW-1:0] win;
    logic             ins;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, aclr, ien, isof, oen, wins;
  logic [DW-1:0]    pix;
  logic [NT*DW-1:0] win;
  logic [2:0]       wrow, wcol;

  logic             c5_ien, c5_isof, c5_aclr, c5_oen, c5_ins;
  logic [DW-1:0]    c5_pix;
  logic [249:0]     c5_win;
  logic [2:0]       c5_row;
  logic [3:0]       c5_col;

  window_gen_kxk #(.DW(DW), .K(K), .IMG_W(W), .IMG_H(H), .ZERO_PAD(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .aclr(aclr), .ien(ien), .isof(isof),
    .per_img_Y(pix), .oen(oen), .win_data(win), .win_row(wrow),
    .win_col(wcol), .win_inside(wins)
  );

  window_gen_kxk #(.DW(DW), .K(5), .IMG_W(10), .IMG_H(6), .ZERO_PAD(0)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .aclr(c5_aclr), .ien(c5_ien), .isof(c5_isof),
    .per_img_Y(c5_pix), .oen(c5_oen), .win_data(c5_win), .win_row(c5_row),
    .win_col(c5_col), .win_inside(c5_ins)
  );

  exp_t             sb[$];
  exp_t             me;
  vec_t             tv[7];
  int               checks = 0, errors = 0;
  int               br, bc, seg, n_acc, n_oen, npop;
  bit               exp_oen, mon;
  logic [NT*DW-1:0] cap[W*H];
  logic             cap_ins[W*H];
  logic [NT*DW-1:0] hw;

  function automatic logic [DW-1:0] pv(input int r, input int c, input int s);
    return DW'(s * 256 + r * 16 + c);
  endfunction

  function automatic exp_t model(input int r, input int c, input int s);
    exp_t e;
    e.win = '0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++) begin
        int rr, cc;
        rr = r - (K - 1 - i);
        cc = c - (K - 1 - j);
        if (rr >= 0 && cc >= 0) e.win[(i*K+j)*DW +: DW] = pv(rr, cc, s);
      end
    e.row = 3'(r);
    e.col = 3'(c);
    e.ins = (r >= K - 1) && (c >= K - 1);
    return e;
  endfunction

  function automatic logic [NT*DW-1:0] mkwin(input int t0, t1, t2, t3, t4, t5, t6, t7, t8);
    return {10'(t8), 10'(t7), 10'(t6), 10'(t5), 10'(t4), 10'(t3), 10'(t2), 10'(t1), 10'(t0)};
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  // One clock of stimulus; accepted pixels get their expected window queued.
  task automatic drive(input bit en, input bit sof, input bit clr);
    ien = en; isof = sof; aclr = clr; pix = DW'($urandom);
    if (clr) begin
      br = 0; bc = 0;
    end else if (en) begin
      if (sof) begin br = 0; bc = 0; end
      pix = pv(br, bc, seg);
      sb.push_back(model(br, bc, seg));
      n_acc++;
      if (bc == W - 1) begin bc = 0; br = (br == H - 1) ? 0 : br + 1; end
      else bc++;
    end
    @(posedge clk); #1;
    exp_oen = en && !clr;
    ien = 1'b0; isof = 1'b0; aclr = 1'b0;
  endtask

  // Mid-cycle monitor: oen must mirror last cycle's acceptance; each pulse
  // pops and compares one expected window.
  always @(negedge clk) begin
    if (mon) begin
      checks++;
      if (oen !== exp_oen) begin
        errors++;
        $display("FAIL oen_timing got %b exp %b", oen, exp_oen);
      end
      if (oen) begin
        n_oen++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_empty got oen with no pending pixel");
        end else begin
          me = sb.pop_front();
          checks++;
          if ({wrow, wcol, wins, win} !== {me.row, me.col, me.ins, me.win}) begin
            errors++;
            $display("FAIL sb got row %0d col %0d ins %0d win %h exp row %0d col %0d ins %0d win %h",
                     wrow, wcol, wins, win, me.row, me.col, me.ins, me.win);
          end
          if (npop < W * H) begin
            cap[npop] = win;
            cap_ins[npop] = wins;
          end
          npop++;
        end
      end
    end
  end

  initial begin
    tv[0] = '{2, 2, mkwin('h00, 'h01, 'h02, 'h10, 'h11, 'h12, 'h20, 'h21, 'h22), 1'b1};
    tv[1] = '{1, 0, mkwin(0, 0, 0, 0, 0, 'h00, 0, 0, 'h10), 1'b0};
    tv[2] = '{0, 0, mkwin(0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0};
    tv[3] = '{5, 7, mkwin('h35, 'h36, 'h37, 'h45, 'h46, 'h47, 'h55, 'h56, 'h57), 1'b1};
    tv[4] = '{3, 1, mkwin(0, 'h10, 'h11, 0, 'h20, 'h21, 0, 'h30, 'h31), 1'b0};
    tv[5] = '{0, 4, mkwin(0, 0, 0, 0, 0, 0, 'h02, 'h03, 'h04), 1'b0};
    tv[6] = '{4, 2, mkwin('h20, 'h21, 'h22, 'h30, 'h31, 'h32, 'h40, 'h41, 'h42), 1'b1};

    aclr = 0; ien = 0; isof = 0; pix = 0; mon = 0; exp_oen = 0;
    c5_ien = 0; c5_isof = 0; c5_aclr = 0; c5_pix = 0;
    br = 0; bc = 0; seg = 0; n_acc = 0; n_oen = 0; npop = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_oen", oen, 0);
    chk("rst_win", win, 0);
    chk("rst_row", wrow, 0);
    chk("rst_col", wcol, 0);
    chk("rst_ins", wins, 0);
    rst_n = 1'b1;
    mon = 1'b1;

    // Continuous stream: one full frame plus the wrap into the next.
    for (int n = 0; n < W * H + 4; n++) drive(1, 0, 0);
    drive(0, 0, 0);
    for (int t = 0; t < 7; t++) begin
      chk($sformatf("tbl_win_%0d_%0d", tv[t].r, tv[t].c), cap[tv[t].r*W+tv[t].c], tv[t].win);
      chk($sformatf("tbl_ins_%0d_%0d", tv[t].r, tv[t].c), cap_ins[tv[t].r*W+tv[t].c], tv[t].ins);
    end

    // Gapped stream; isof without ien must be ignored.
    for (int n = 0; n < 140; n++) begin
      if (n == 37) drive(0, 1, 0);
      else drive(1'($urandom_range(0, 1)), 0, 0);
    end
    drive(0, 0, 0);
    chk("oen_count", n_oen, n_acc);

    // Mid-frame resync at (3,5).
    while (!(br == 3 && bc == 5)) drive(1, 0, 0);
    seg = 1;
    drive(1, 1, 0);
    hw = '0; hw[(NT-1)*DW +: DW] = pv(0, 0, 1);
    chk("sof_row", wrow, 0);
    chk("sof_col", wcol, 0);
    chk("sof_win", win, hw);
    for (int n = 0; n < 20; n++) drive(1, 0, 0);

    // Clear with a simultaneous pixel at (2,4).
    while (!(br == 2 && bc == 4)) drive(1, 0, 0);
    drive(1, 0, 1);
    chk("aclr_oen", oen, 0);
    seg = 2;
    drive(1, 0, 0);
    hw = '0; hw[(NT-1)*DW +: DW] = pv(0, 0, 2);
    chk("aclr_pos", {wrow, wcol}, 0);
    chk("aclr_win", win, hw);
    for (int n = 0; n < 12; n++) drive(1, 0, 0);

    // Asynchronous reset mid-line.
    while (!(br == 1 && bc == 3)) drive(1, 0, 0);
    drive(1, 0, 0);
    #2 rst_n = 1'b0;
    sb.delete();
    exp_oen = 1'b0;
    #1;
    chk("arst_oen", oen, 0);
    chk("arst_win", win, 0);
    chk("arst_pos", {wrow, wcol}, 0);
    chk("arst_ins", wins, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    br = 0; bc = 0; seg = 3;
    drive(0, 0, 0);
    drive(1, 0, 0);
    chk("arst_first_oen", oen, 1);
    chk("arst_first_pos", {wrow, wcol}, 0);
    for (int n = 0; n < 20; n++) drive(1, 0, 0);
    drive(0, 0, 0);
    drive(0, 0, 0);
    chk("sb_drain", sb.size(), 0);

    // 5x5 raw mode, two frames back to back without isof.
    for (int n = 0; n < 120; n++) begin
      c5_ien = 1'b1;
      c5_pix = DW'(n + 1);
      @(posedge clk); #1;
      if (n == 59) chk("k5_last_pos", {c5_row, c5_col}, {3'd5, 4'd9});
      if (n == 60) begin
        chk("k5_wrap_pos", {c5_row, c5_col}, 0);
        chk("k5_wrap_ins", c5_ins, 0);
        chk("k5_stale_tap", c5_win[(3*5+4)*DW +: DW], 51);
        chk("k5_oen", c5_oen, 1);
      end
      if (n == 104) begin
        chk("k5_44_pos", {c5_row, c5_col}, {3'd4, 4'd4});
        chk("k5_44_ins", c5_ins, 1);
        chk("k5_44_tap00", c5_win[0 +: DW], 61);
      end
    end
    c5_ien = 1'b0;
    @(posedge clk); #1;
    chk("k5_oen_off", c5_oen, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/window_gen_kxk.md
# window_gen_kxk

Parametrised K×K sliding-window generator for the recognition pixel pipeline, and successor to the fixed 3×3, 10-bit window buffer. It accepts one pixel per enabled clock in raster order and keeps K−1 line delays internally. On each accepted pixel it presents the full K×K neighbourhood one clock later, with the pixel's frame coordinates and an inside-frame flag. Out-of-frame taps can optionally be forced to zero, so downstream filters (Sobel, erosion/dilation, 5×5 blur) need no edge logic.

## Interface
- DW, 10, pixel width in bits
- K, 3, window size; odd, 3..7
- IMG_W, 640, pixels per line; ≥ K
- IMG_H, 480, lines per frame; ≥ K
- ZERO_PAD, 1, 1 = out-of-frame taps output as 0; 0 = raw buffer contents
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- aclr  in  1  synchronous clear of counters, window and output pipeline
- ien  in  1  input pixel valid; pixel accepted on clk rising edge when 1
- isof  in  1  start of frame; qualified by ien; marks pixel (0,0)
- per_img_Y  in  DW  input pixel
- oen  out  1  window valid, one pulse per accepted pixel
- win_data  out  K*K*DW  window; tap (i,j) at bits [(i*K+j)*DW +: DW]; i=0 oldest row, j=0 oldest column; tap (K−1,K−1) = newest pixel
- win_row  out  clog2(IMG_H)  row of newest pixel
- win_col  out  clog2(IMG_W)  column of newest pixel
- win_inside  out  1  1 when every tap lies inside the current frame

## Operation
- Counters col_cnt, row_cnt give the coordinates of the pixel being accepted.
  - On an accepted pixel, col_cnt increments. At IMG_W−1 it wraps to 0 and row_cnt increments.
  - At (IMG_H−1, IMG_W−1) both wrap to 0.
- ien=1 with isof=1 forces the accepted pixel to coordinate (0,0); the counters then continue from (0,1). This resynchronises a frame mid-stream. isof with ien=0 is ignored.
- Line delay: K−1 cascaded delays of IMG_W pixels each, advanced only when ien=1. Row K−1 is the input pixel; row i is the output of delay (K−1−i).
- Window register: K rows × K columns. On ien=1 every row shifts toward j=0 and loads its newest row input at j=K−1. On ien=0 the window holds.
- Mask, evaluated on the coordinates of the newest pixel: tap (i,j) is outside when row < K−1−i or col < K−1−j.
  - ZERO_PAD=1: outside taps drive 0 on win_data. The register contents are not altered.
  - ZERO_PAD=0: outside taps pass raw contents, i.e. stale pixels from the previous line or frame.
- win_inside = (win_row ≥ K−1) && (win_col ≥ K−1).
- aclr=1 has priority over ien. It clears col_cnt, row_cnt, the window registers, oen and win_row/win_col. Line-delay contents are not cleared; the zero mask covers them.

## Timing
- Latency: pixel accepted at edge t appears at tap (K−1,K−1) with oen=1 after edge t+1. oen is ien registered once.
- win_data, win_row, win_col and win_inside are all valid in the same cycle as oen and hold until the next accepted pixel.
- Throughput: one pixel per clock. ien may deassert on any cycle without data loss.
- Reset values (rst_n=0): oen=0, win_data=0, win_row=0, win_col=0, win_inside=0, counters=0.
- Line wrap: the first output of each row (win_col=0) has columns 0..K−2 outside. With ZERO_PAD=1 they read 0.
- Frame wrap: after pixel (IMG_H−1, IMG_W−1), the next pixel is (0,0) whether or not isof is asserted.
- Simultaneous aclr and ien: the pixel is dropped and oen=0 next cycle.
- rst_n deasserted mid-frame: the first accepted pixel after reset is (0,0).

## Structure
- Shared package: tap index function (i*K+j), coordinate widths via clog2, ZERO_PAD constants.
- One sub-module, line_delay: a clock-enabled IMG_W×DW delay line with parameters DW and IMG_W. It is instantiated K−1 times in a generate loop and maps to shift-tap or RAM ring inference.
- Counters, window register, mask and output registers stay in the top level.

## Test plan
- K=3, IMG_W=8, IMG_H=6, ZERO_PAD=1, pixel value = row*16+col, ien=1 continuous. At (2,2) the window rows read {0x00,0x01,0x02}, {0x10,0x11,0x12}, {0x20,0x21,0x22}, win_inside=1. At (1,0) every tap except (1,2)=0x00 and (2,2)=0x10 is 0.
- Same setup with ien toggled pseudo-randomly (about 50%): the window sequence is identical to the continuous case, exactly one oen pulse per accepted pixel, and oen is always 1 cycle after ien.
- K=5, IMG_W=10, two back-to-back frames without isof: the second frame starts at (0,0) after 60 pixels. In the second frame with ZERO_PAD=0, tap (0,0) at (4,4) = pixel (0,0) of frame 2.
- isof asserted at frame-1 position (3,5): that pixel reports win_row=0, win_col=0, and all taps except the newest are zero with ZERO_PAD=1.
- aclr pulse at (2,4) with ien=1: no oen the next cycle, and the next pixel reports (0,0) with an all-zero window except the newest tap.
- rst_n asserted asynchronously mid-line: all outputs 0 immediately. After release the first pixel is at (0,0) with oen 1 cycle later.
